// File: rtl/sad_pkg.sv
// Shared definitions for the SAD accumulator: state encoding, sample width
// and the counter width helper.
package sad_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } sad_state_e;

  localparam int DIFF_W = 4;

  // Width of the in-frame sample counter; a frame of n samples counts 0..n-1.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sad_sample_counter.sv
// Counts accepted samples within a frame and flags the last one.
module sad_sample_counter
  import sad_pkg::*;
#(
  parameter int N_SAMPLES = 8,
  localparam int CNT_W = cnt_w(N_SAMPLES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             accept,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  assign last = (cnt == CNT_W'(N_SAMPLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sad_accumulator.sv
// Sum-of-absolute-differences frame accumulator with valid/ready in and out.
// Define SAD_SATURATE_EN to clamp the running sum instead of wrapping it.
module sad_accumulator
  import sad_pkg::*;
#(
  parameter int N_SAMPLES = 8,
  parameter int ACC_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              diff_valid,
  output logic              diff_ready,
  input  logic [DIFF_W-1:0] abs_diff,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [ACC_W-1:0]  sad_sum,
  output logic              sad_sat
);

  localparam int CNT_W = cnt_w(N_SAMPLES);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on the partner's valid, and a raised valid
  // holds its data until that transfer (or reset).
  sad_state_e       state;
  sad_state_e       state_next;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             clr_accum;
  logic             take;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum_next;

  assign clr_accum = clr && (state == ST_ACCUM);
  assign take      = diff_valid && diff_ready && !clr_accum;

  sad_sample_counter #(
    .N_SAMPLES(N_SAMPLES)
  ) u_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_accum),
    .accept(take),
    .cnt   (cnt),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_ACCUM;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_ACCUM: if (take && last) state_next = ST_HOLD;
      ST_HOLD:  if (sum_ready)    state_next = ST_ACCUM;
      default:  state_next = ST_ACCUM;
    endcase
  end

  always_comb begin
    diff_ready = (state == ST_ACCUM);
    sum_valid  = (state == ST_HOLD);
  end

`ifdef SAD_SATURATE_EN
  logic [ACC_W:0] wide_sum;
  logic           clamp_now;
  logic           sat_flag;

  assign wide_sum  = {1'b0, acc} + (ACC_W + 1)'(abs_diff);
  assign clamp_now = wide_sum[ACC_W];
  assign sum_next  = clamp_now ? '1 : wide_sum[ACC_W-1:0];

  // Remembers any clamp seen earlier in the current frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_flag <= 1'b0;
      sad_sat  <= 1'b0;
    end else if (clr_accum) begin
      sat_flag <= 1'b0;
    end else if (take) begin
      if (last) begin
        sat_flag <= 1'b0;
        sad_sat  <= sat_flag | clamp_now;
      end else begin
        sat_flag <= sat_flag | clamp_now;
      end
    end
  end
`else
  assign sum_next = acc + ACC_W'(abs_diff);
  assign sad_sat  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc     <= '0;
      sad_sum <= '0;
    end else if (clr_accum) begin
      acc <= '0;
    end else if (take) begin
      if (last) begin
        acc     <= '0;
        sad_sum <= sum_next;
      end else begin
        acc <= sum_next;
      end
    end
  end

endmodule

// File: doc/sad_accumulator.md
# sad_accumulator

Sequential sum-of-absolute-differences (SAD) stage placed directly downstream of the 4-bit absolute-difference unit. It takes the `AbsDiff` result as a stream of samples under a valid/ready handshake and accumulates N_SAMPLES of them into one frame sum. It then presents the sum on an output handshake and holds it until the consumer takes it. Typical use is block matching and error metrics over 4-bit operand pairs.

## Interface
- `N_SAMPLES`, default 8: samples per frame; legal range 2..255.
- `ACC_W`, default 8: accumulator and output width; legal range 4..16.
- `clk`  input  1: single clock; all logic acts on the rising edge.
- `rst_n`  input  1: synchronous reset, active-low.
- `clr`  input  1: synchronous frame abort; drops the partial frame.
- `diff_valid`  input  1: `abs_diff` holds a valid sample.
- `diff_ready`  output  1: the block accepts a sample this cycle.
- `abs_diff`  input  4: unsigned sample, 0..15.
- `sum_valid`  output  1: `sad_sum` holds a completed frame sum.
- `sum_ready`  input  1: the consumer takes the sum this cycle.
- `sad_sum`  output  ACC_W: completed frame sum.
- `sad_sat`  output  1: the frame sum was clamped. This port is always present.

## Operation
- There are two states. ST_ACCUM accepts samples. ST_HOLD presents the result.
- `diff_ready` is 1 in ST_ACCUM and 0 in ST_HOLD. It is decoded from the state register only; it never depends on `sum_ready`.
- A sample is accepted when `diff_valid` and `diff_ready` are both high on the same edge.
- On acceptance: `acc <= acc + abs_diff` and `cnt <= cnt + 1`. The addition zero-extends `abs_diff` to ACC_W.
- Frame end: acceptance while `cnt == N_SAMPLES-1` does the following in one edge:
  - `sad_sum <= acc + abs_diff` (after the overflow rule).
  - `sum_valid <= 1`.
  - `acc <= 0` and `cnt <= 0`.
  - The state moves to ST_HOLD.
- In ST_HOLD, `sad_sum` and `sad_sat` are stable. `diff_valid` is ignored and no sample is consumed.
- If `sum_valid` and `sum_ready` are both high on an edge: `sum_valid <= 0` and the state returns to ST_ACCUM. `diff_ready` is high on the next cycle. There is no same-cycle bypass.
- `clr` behaviour:
  - In ST_ACCUM: `acc <= 0` and `cnt <= 0`. A sample offered in the same cycle is dropped, and `diff_ready` stays high.
  - In ST_HOLD: no effect. A completed result is never discarded.
- Priority order: `rst_n` first, then `clr`, then acceptance.
- Overflow rule is set by the macro described under Configuration.

## Timing
- Reset values (one edge with `rst_n` = 0):
  - State is ST_ACCUM; `acc`, `cnt`, `sad_sum` are 0.
  - `sum_valid` = 0, `sad_sat` = 0, `diff_ready` = 1.
- Reset mid-frame or in ST_HOLD discards all partial and pending results.
- Throughput: one sample per cycle while in ST_ACCUM.
- Latency: `sum_valid` rises on the edge that accepts the last sample, so it is visible in the following cycle.
- Minimum frame period is N_SAMPLES + 1 cycles: the last-sample edge plus one ST_HOLD cycle with `sum_ready` = 1.
- Back-pressure: ST_HOLD persists for any number of cycles while `sum_ready` = 0.
- Handshake rules:
  - `sad_sum` and `sad_sat` are registered and change only at frame end.
  - `sum_valid` does not drop without a handshake, except on reset.

## Configuration
- Macro: `SAD_SATURATE_EN`.
- Defined:
  - Each accumulation clamps at 2^ACC_W − 1.
  - `sad_sat` is set to 1 with the frame sum if any clamp happened during that frame.
  - The clamp flag clears at frame start and on `clr`.
- Undefined:
  - Accumulation wraps modulo 2^ACC_W.
  - `sad_sat` is tied to 0.

## Structure
- Shared package `sad_pkg` contains:
  - the state encoding (ST_ACCUM, ST_HOLD);
  - `DIFF_W = 4`;
  - the width helper `CNT_W = $clog2(N_SAMPLES)`.
- One sub-module, `sad_sample_counter`. It owns `cnt`, clears on `clr`, reset or frame end, increments on acceptance, and outputs the `last` flag (`cnt == N_SAMPLES-1`).
- The top level instantiates the absolute-difference unit ahead of this block. Its `AbsDiff` output connects to `abs_diff`.

## Test plan
- Basic frame: default parameters, 8 back-to-back samples of 3, `sum_ready` = 1. Expect `sad_sum` = 24 and `sum_valid` high for exactly one cycle, starting the cycle after the 8th sample.
- Back-pressure: samples 15,0,15,0,15,0,15,0 with `sum_ready` = 0 for 5 cycles.
  - Expect `sad_sum` = 60, held stable.
  - Expect `diff_ready` = 0 for the whole hold.
  - Expect samples offered during the hold to be ignored.
  - The next frame of 8 samples of 1 gives 8.
- Abort: 4 samples of 9, then `clr`, then 8 samples of 2. Expect `sad_sum` = 16.
- Reset mid-frame: 5 samples of 7, then `rst_n` low for one cycle, then 8 samples of 1.
  - Expect all outputs at their reset values during reset.
  - Expect `sad_sum` = 8 afterwards.
- Overflow: ACC_W = 6, 8 samples of 15 (true sum 120).
  - With `SAD_SATURATE_EN`: `sad_sum` = 63 and `sad_sat` = 1.
  - Without it: `sad_sum` = 56 and `sad_sat` = 0.
- Gapped input: `diff_valid` toggling 1,0,1,0 with 8 samples of 5. Expect `sad_sum` = 40 and only valid cycles counted.
